spi_ram_arbiter: RTL and testbench

Shares the single-port RAM between the SPI slave command stream and a local host port (req/ack).
- Decodes the 2-bit SPI opcode and holds the write/read address registers.
- Buffers one SPI RAM access and runs a priority arbiter with starvation protection for the host.
- Sits between the SPI slave and the RAM macro; drives the RAM port directly.

---
 rtl/spi_ram_arbiter_pkg.sv | 22 ++
 rtl/spi_ram_arbiter_if.sv | 12 +
 rtl/spi_ram_arbiter_cmd_buffer.sv | 26 ++
 rtl/spi_ram_arbiter.sv | 110 +++++++++++
 tb/tb_spi_ram_arbiter.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/spi_ram_arbiter_pkg.sv
// spi_ram_arbiter_pkg: shared types and sizes for the SPI/host RAM arbiter
package spi_ram_arbiter_pkg;
  localparam int MEM_DEPTH = 256;
  localparam int ADDR_SIZE = $clog2(MEM_DEPTH);
  localparam int MEM_WIDTH = 8;
  localparam int STARVE_LIMIT = 4;
  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } spi_cmd_e;
  typedef enum logic [1:0] {IDLE, SPI_RD, HOST_RD} arb_state_e;
  typedef struct packed {
    logic                 we;
    logic [ADDR_SIZE-1:0] addr;
    logic [MEM_WIDTH-1:0] data;
  } spi_op_t;
  function automatic logic is_ram_cmd(spi_cmd_e c);
    return c[0];
  endfunction
endpackage

// File: rtl/spi_ram_arbiter_if.sv
// spi_ram_arbiter_if: local host req/ack RAM port
interface spi_ram_arbiter_if;
  import spi_ram_arbiter_pkg::*;
  logic                 req;
  logic                 we;
  logic [ADDR_SIZE-1:0] addr;
  logic [MEM_WIDTH-1:0] wdata;
  logic                 ack;
  logic [MEM_WIDTH-1:0] rdata;
  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/spi_ram_arbiter_cmd_buffer.sv
// spi_cmd_buffer: one-entry pending SPI RAM op with sticky overrun flag
module spi_cmd_buffer
  import spi_ram_arbiter_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  spi_op_t push_op,
  input  logic    pop,
  output logic    valid,
  output spi_op_t op,
  output logic    overrun
);
  // a push lands when the slot is free or empties on the same edge, else it is dropped
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid   <= 1'b0;
      op      <= '0;
      overrun <= 1'b0;
    end else begin
      valid <= push || (valid && !pop);
      if (push && (!valid || pop)) op <= push_op;
      if (push && valid && !pop) overrun <= 1'b1;
    end
  end
endmodule

// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: shares a single-port RAM between SPI commands and a host port
module spi_ram_arbiter
  import spi_ram_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = spi_ram_arbiter_pkg::STARVE_LIMIT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_valid,
  input  logic [MEM_WIDTH+1:0] din,
  output logic [MEM_WIDTH-1:0] dout,
  output logic                 tx_valid,
  output logic                 spi_overrun,
  spi_ram_arbiter_if.slave     host,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [MEM_WIDTH-1:0] ram_wdata,
  input  logic [MEM_WIDTH-1:0] ram_rdata
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  spi_cmd_e             cmd;
  logic [ADDR_SIZE-1:0] addr_wr, addr_rd;
  logic                 push, pend_valid;
  spi_op_t              push_op, pend_op;
  arb_state_e           state, state_nx;
  logic [SW-1:0]        starve_cnt;
  logic                 host_req_eff, host_force, spi_gnt, host_gnt;

  assign cmd = spi_cmd_e'(din[MEM_WIDTH+1:MEM_WIDTH]);
  assign push = rx_valid && is_ram_cmd(cmd);
  assign push_op = '{
    we:   cmd == WR_DATA,
    addr: cmd == WR_DATA ? addr_wr : addr_rd,
    data: cmd == WR_DATA ? din[MEM_WIDTH-1:0] : '0
  };

  spi_cmd_buffer u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .push_op (push_op),
    .pop     (spi_gnt),
    .valid   (pend_valid),
    .op      (pend_op),
    .overrun (spi_overrun)
  );

  // address set-up commands only load the address registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_wr <= '0;
      addr_rd <= '0;
    end else begin
      if (rx_valid && cmd == WR_ADDR) addr_wr <= din[ADDR_SIZE-1:0];
      if (rx_valid && cmd == RD_ADDR) addr_rd <= din[ADDR_SIZE-1:0];
    end
  end

  // grant selection; the ack cycle masks a still-held host_req so it is not re-issued
  always_comb begin
    host_req_eff = host.req && !host.ack;
    host_force   = host_req_eff && starve_cnt == SW'(STARVE_LIMIT);
    spi_gnt      = state == IDLE && pend_valid && !host_force;
    host_gnt     = state == IDLE && host_req_eff && !spi_gnt;
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end

  // reads park in a capture state for one cycle; writes stay in IDLE
  always_comb begin
    state_nx = IDLE;
    if (spi_gnt && !pend_op.we) state_nx = SPI_RD;
    else if (host_gnt && !host.we) state_nx = HOST_RD;
  end

  // RAM port driven straight from the winning request
  always_comb begin
    ram_en    = spi_gnt || host_gnt;
    ram_we    = spi_gnt ? pend_op.we : host_gnt && host.we;
    ram_addr  = spi_gnt ? pend_op.addr : host_gnt ? host.addr : '0;
    ram_wdata = spi_gnt ? pend_op.data : host_gnt && host.we ? host.wdata : '0;
  end

  // read-data capture and completion strobes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_valid   <= 1'b0;
      dout       <= '0;
      host.ack   <= 1'b0;
      host.rdata <= '0;
    end else begin
      tx_valid <= state == SPI_RD;
      if (state == SPI_RD) dout <= ram_rdata;
      host.ack <= (host_gnt && host.we) || state == HOST_RD;
      if (state == HOST_RD) host.rdata <= ram_rdata;
    end
  end

  // count host losses, saturating; any host grant clears it
  always_ff @(posedge clk) begin
    if (!rst_n) starve_cnt <= '0;
    else if (host_gnt) starve_cnt <= '0;
    else if (spi_gnt && host_req_eff && starve_cnt != SW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
  end
endmodule

// File: tb/tb_spi_ram_arbiter.sv
// tb_spi_ram_arbiter: directed checks of SPI decode, arbitration, starvation and overrun
module tb_spi_ram_arbiter;
  import spi_ram_arbiter_pkg::*;
  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 rx_valid;
  logic [MEM_WIDTH+1:0] din;
  logic [MEM_WIDTH-1:0] dout;
  logic                 tx_valid, spi_overrun;
  logic                 ram_en, ram_we;
  logic [ADDR_SIZE-1:0] ram_addr;
  logic [MEM_WIDTH-1:0] ram_wdata, ram_rdata;
  logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];
  int n_tests = 0;
  int n_fail = 0;

  spi_ram_arbiter_if host_bus ();

  spi_ram_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_valid    (rx_valid),
    .din         (din),
    .dout        (dout),
    .tx_valid    (tx_valid),
    .spi_overrun (spi_overrun),
    .host        (host_bus),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
  );

  always #5 clk = ~clk;

  // synchronous single-port RAM model
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else ram_rdata <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic spi(input logic [1:0] c, input logic [7:0] p);
    rx_valid = 1'b1;
    din = {c, p};
    tick();
    rx_valid = 1'b0;
    din = '0;
    #1;
  endtask

  initial begin
    for (int i = 0; i < MEM_DEPTH; i++) mem[i] = 8'(i) ^ 8'h5A;
    ram_rdata = '0;
    rst_n = 1'b0;
    rx_valid = 1'b0;
    din = '0;
    host_bus.req = 1'b0;
    host_bus.we = 1'b0;
    host_bus.addr = '0;
    host_bus.wdata = '0;
    tick();
    tick();
    chk("rst_dout", 32'(dout), 0);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_overrun", 32'(spi_overrun), 0);
    chk("rst_host_ack", 32'(host_bus.ack), 0);
    chk("rst_host_rdata", 32'(host_bus.rdata), 0);
    chk("rst_ram_en", 32'(ram_en), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    rst_n = 1'b1;
    tick();
    // read with no prior address command targets address 0
    spi(2'b11, 8'hFF);
    chk("rd0_ram_en", 32'(ram_en), 1);
    chk("rd0_ram_we", 32'(ram_we), 0);
    chk("rd0_ram_addr", 32'(ram_addr), 0);
    tick();
    chk("rd0_tx_early", 32'(tx_valid), 0);
    tick();
    chk("rd0_tx_valid", 32'(tx_valid), 1);
    chk("rd0_dout", 32'(dout), 32'h5A);
    tick();
    chk("rd0_tx_pulse", 32'(tx_valid), 0);
    chk("rd0_dout_hold", 32'(dout), 32'h5A);
    // write then read back through SPI
    spi(2'b00, 8'h3C);
    spi(2'b01, 8'hA5);
    chk("wr_ram_we", 32'(ram_we), 1);
    chk("wr_ram_addr", 32'(ram_addr), 32'h3C);
    chk("wr_ram_wdata", 32'(ram_wdata), 32'hA5);
    spi(2'b10, 8'h3C);
    spi(2'b11, 8'h00);
    chk("rd_ram_addr", 32'(ram_addr), 32'h3C);
    tick();
    tick();
    chk("rd_tx_valid", 32'(tx_valid), 1);
    chk("rd_dout", 32'(dout), 32'hA5);
    tick();
    // host write starved by a continuous SPI write stream
    spi(2'b00, 8'h50);
    spi(2'b01, 8'hA0);
    host_bus.req = 1'b1;
    host_bus.we = 1'b1;
    host_bus.addr = 8'h10;
    host_bus.wdata = 8'h99;
    rx_valid = 1'b1;
    din = {2'b01, 8'hB0};
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("starve_spi_addr", 32'(ram_addr), 32'h50);
      chk("starve_no_ack", 32'(host_bus.ack), 0);
      tick();
      din = {2'b01, 8'(8'hB1 + i)};
      #1;
    end
    chk("starve_host_addr", 32'(ram_addr), 32'h10);
    chk("starve_host_wdata", 32'(ram_wdata), 32'h99);
    chk("starve_host_we", 32'(ram_we), 1);
    chk("starve_ovr_before", 32'(spi_overrun), 0);
    tick();
    rx_valid = 1'b0;
    din = '0;
    host_bus.req = 1'b0;
    #1;
    chk("starve_host_ack", 32'(host_bus.ack), 1);
    chk("starve_overrun", 32'(spi_overrun), 1);
    chk("starve_cnt_clear", 32'(dut.starve_cnt), 0);
    tick();
    chk("starve_ack_pulse", 32'(host_bus.ack), 0);
    tick();
    tick();
    chk("starve_mem_host", 32'(mem[8'h10]), 32'h99);
    chk("starve_mem_spi", 32'(mem[8'h50]), 32'hB3);
    chk("starve_ovr_sticky", 32'(spi_overrun), 1);
    // reset on the capture edge of an SPI read
    spi(2'b11, 8'h00);
    tick();
    rst_n = 1'b0;
    tick();
    chk("rstrd_tx_valid", 32'(tx_valid), 0);
    chk("rstrd_dout", 32'(dout), 0);
    chk("rstrd_state", 32'(dut.state), 32'(IDLE));
    chk("rstrd_overrun", 32'(spi_overrun), 0);
    rst_n = 1'b1;
    tick();
    chk("rstrd_tx_after", 32'(tx_valid), 0);
    // host wins the free slot with a read; the next SPI command is dropped
    host_bus.req = 1'b1;
    host_bus.we = 1'b0;
    host_bus.addr = 8'h3C;
    spi(2'b01, 8'h11);
    chk("ovr_state", 32'(dut.state), 32'(HOST_RD));
    rx_valid = 1'b1;
    din = {2'b01, 8'h22};
    tick();
    rx_valid = 1'b0;
    din = '0;
    host_bus.req = 1'b0;
    #1;
    chk("ovr_flag", 32'(spi_overrun), 1);
    chk("ovr_host_ack", 32'(host_bus.ack), 1);
    chk("ovr_host_rdata", 32'(host_bus.rdata), 32'hA5);
    tick();
    tick();
    chk("ovr_mem_kept", 32'(mem[0]), 32'h11);
    chk("ovr_sticky", 32'(spi_overrun), 1);
    // same-address hazard: pending SPI write goes before the host read
    spi(2'b00, 8'h20);
    spi(2'b01, 8'h77);
    host_bus.req = 1'b1;
    host_bus.we = 1'b0;
    host_bus.addr = 8'h20;
    #1;
    chk("haz_spi_first_we", 32'(ram_we), 1);
    chk("haz_spi_first_addr", 32'(ram_addr), 32'h20);
    tick();
    chk("haz_host_en", 32'(ram_en), 1);
    chk("haz_host_we", 32'(ram_we), 0);
    tick();
    chk("haz_no_ack_yet", 32'(host_bus.ack), 0);
    tick();
    host_bus.req = 1'b0;
    #1;
    chk("haz_host_ack", 32'(host_bus.ack), 1);
    chk("haz_host_rdata", 32'(host_bus.rdata), 32'h77);
    tick();
    chk("haz_ack_pulse", 32'(host_bus.ack), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
